sync_instruction_memory: RTL and testbench
==========================================

SYNC_INSTRUCTION_MEMORY -- requirements
Module: sync_instruction_memory

Interface
REQ-001 SHALL have parameter DATA_W, default 32, instruction word width in bits.
REQ-002 SHALL have parameter ADDR_W, default 64, byte-address width.
REQ-003 SHALL have parameter DEPTH, default 64, number of words stored.
REQ-004 SHALL have parameter RD_LAT, default 2, access latency in cycles; legal range 1..15.
REQ-005 SHALL have port CLK, input, 1 bit, sole clock; all state updates on the rising edge.
REQ-006 SHALL have port Reset, input, 1 bit, asynchronous active-high reset.
REQ-007 SHALL have port ReqValid, input, 1 bit, fetch request present.
REQ-008 SHALL have port ReqReady, output, 1 bit, block can accept a request.
REQ-009 SHALL have port Address, input, ADDR_W bits, fetch byte address.
REQ-010 SHALL have port RespValid, output, 1 bit, Data/Fault valid.
REQ-011 SHALL have port RespReady, input, 1 bit, consumer accepts the response.
REQ-012 SHALL have port Data, output, DATA_W bits, fetched instruction word.
REQ-013 SHALL have port Fault, output, 1 bit, access was misaligned or out of range.
REQ-014 SHALL have port LoadEn, input, 1 bit, program-load write strobe.
REQ-015 SHALL have port LoadAddr, input, ADDR_W bits, program-load byte address.
REQ-016 SHALL have port LoadData, input, DATA_W bits, program-load word.

Function
REQ-017 SHALL implement FSM states IDLE, WAIT, RESP; ReqReady = 1 only in IDLE.
REQ-018 SHALL accept a request on an edge with ReqValid=1 in IDLE, capture word mem[Address>>2] and move to WAIT, with a latency counter loaded to RD_LAT-1.
REQ-019 SHALL move WAIT->RESP when the counter reaches 0, so RespValid rises exactly RD_LAT cycles after the accept edge.
REQ-020 SHALL hold RespValid, Data and Fault stable in RESP until an edge with RespReady=1, then return to IDLE; a new request is accepted no earlier than the following edge.
REQ-021 SHALL set Fault=1 and Data=0 when Address[1:0]!=0 or Address>>2 >= DEPTH; faulting requests keep normal latency.
REQ-022 SHALL write LoadData to word LoadAddr>>2 on an edge with LoadEn=1 in any state; misaligned or out-of-range loads are ignored.
REQ-023 SHALL give a load to the word being captured at the same edge the old contents; loads after the accept edge do not alter an in-flight response.
REQ-024 SHALL drive Data=0 and Fault=0 whenever RespValid=0.

Reset
REQ-025 SHALL, while Reset=1, force state IDLE, ReqReady=1, RespValid=0, Data=0, Fault=0, and clear the counter and prefetch buffer.
REQ-026 SHALL drop any in-flight request on reset without a response; array contents are not reset.

Configuration
REQ-027 SHALL, with IMEM_PREFETCH_EN defined, on each RESP->IDLE transition load a one-entry buffer with tag Address+4 and the word at that address; an accept in IDLE whose Address equals a valid tag responds with RespValid one cycle after the accept edge.
REQ-028 SHALL invalidate the prefetch buffer on a load to its tag word, on reset, and when the tag is misaligned or out of range.
REQ-029 SHALL, without IMEM_PREFETCH_EN, contain no buffer and always use RD_LAT latency.

Structure
REQ-030 SHALL place the FSM state enum, the word-index function and the RD_LAT bounds constants in shared package imem_pkg.
REQ-031 SHALL put storage in sub-module imem_array (one read port, one synchronous write port, DEPTH x DATA_W).

Verification
REQ-032 SHALL check: load 0xF84003E9 at 0x0, request 0x0, RD_LAT=2 -> RespValid on cycle 2, Data=0xF84003E9, Fault=0.
REQ-033 SHALL check: request 0x2, then request 0x100 with DEPTH=64 -> each gives Fault=1, Data=0 after RD_LAT cycles.
REQ-034 SHALL check: RespReady held 0 for 3 cycles -> Data stable, ReqReady=0 throughout, IDLE one edge after RespReady=1.
REQ-035 SHALL check: Reset pulsed during WAIT -> RespValid=0 immediately, ReqReady=1, no response emitted after release.
REQ-036 SHALL check: load at 0x4 on the accept edge of request 0x4 -> old word returned; new word on the next fetch.
REQ-037 SHALL check, with IMEM_PREFETCH_EN: fetch 0x0 then 0x4 -> second latency 1; repeat with a load to 0x4 in between -> latency RD_LAT and the new word.

Source files
------------

// File: rtl/imem_pkg.sv
// rtl/imem_pkg.sv - shared state enum, latency bounds and address helpers for the instruction memory
package imem_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        WAIT = 2'd1,
        RESP = 2'd2
    } imem_state_e;

    localparam int RD_LAT_MIN = 1;
    localparam int RD_LAT_MAX = 15;
    localparam int CNT_W      = 4;
    localparam int MAX_ADDR_W = 128;

    function automatic logic [MAX_ADDR_W-1:0] word_index(input logic [MAX_ADDR_W-1:0] addr);
        return addr >> 2;
    endfunction

    // A byte address is usable only if word aligned and inside the array.
    function automatic logic addr_ok(input logic [MAX_ADDR_W-1:0] addr, input int depth);
        return (addr[1:0] == 2'b00) && (word_index(addr) < MAX_ADDR_W'(depth));
    endfunction

    function automatic int clamp_lat(input int lat);
        if (lat < RD_LAT_MIN) return RD_LAT_MIN;
        if (lat > RD_LAT_MAX) return RD_LAT_MAX;
        return lat;
    endfunction

    function automatic int idx_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage

// File: rtl/imem_array.sv
// rtl/imem_array.sv - DEPTH x DATA_W word storage, one combinational read port, one synchronous write port
module imem_array #(
    parameter int DATA_W = 32,
    parameter int DEPTH  = 64,
    parameter int IDX_W  = 6
) (
    input  logic              clk_i,
    input  logic              we_i,
    input  logic [IDX_W-1:0]  waddr_i,
    input  logic [DATA_W-1:0] wdata_i,
    input  logic [IDX_W-1:0]  raddr_i,
    output logic [DATA_W-1:0] rdata_o
);

    logic [DATA_W-1:0] mem [DEPTH];

    // Contents are deliberately not reset; program load fills them.
    always_ff @(posedge clk_i) begin
        if (we_i) begin
            mem[waddr_i] <= wdata_i;
        end
    end

    assign rdata_o = mem[raddr_i];

endmodule

// File: rtl/sync_instruction_memory.sv
// rtl/sync_instruction_memory.sv - request/response instruction fetch memory with fixed read latency
// Optional next-word prefetch buffer enabled by IMEM_PREFETCH_EN.
module sync_instruction_memory
    import imem_pkg::*;
#(
    parameter int DATA_W = 32,
    parameter int ADDR_W = 64,
    parameter int DEPTH  = 64,
    parameter int RD_LAT = 2
) (
    input  logic              CLK,
    input  logic              Reset,
    input  logic              ReqValid,
    output logic              ReqReady,
    input  logic [ADDR_W-1:0] Address,
    output logic              RespValid,
    input  logic              RespReady,
    output logic [DATA_W-1:0] Data,
    output logic              Fault,
    input  logic              LoadEn,
    input  logic [ADDR_W-1:0] LoadAddr,
    input  logic [DATA_W-1:0] LoadData
);

    localparam int              IDX_W  = idx_width(DEPTH);
    localparam int              LAT    = clamp_lat(RD_LAT);
    localparam logic [CNT_W-1:0] LAT_M1 = CNT_W'(LAT - 1);

    imem_state_e       state_q, state_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [DATA_W-1:0] data_q, data_d;
    logic              fault_q, fault_d;

    logic              req_ok;
    logic              load_ok;
    logic              load_we;
    logic [IDX_W-1:0]  load_idx;
    logic [ADDR_W-1:0] rd_addr;
    logic [IDX_W-1:0]  rd_idx;
    logic [DATA_W-1:0] rd_data;

    assign req_ok   = addr_ok(MAX_ADDR_W'(Address), DEPTH);
    assign load_ok  = addr_ok(MAX_ADDR_W'(LoadAddr), DEPTH);
    assign load_we  = LoadEn && load_ok;
    assign load_idx = IDX_W'(word_index(MAX_ADDR_W'(LoadAddr)));
    assign rd_idx   = IDX_W'(word_index(MAX_ADDR_W'(rd_addr)));

    imem_array #(
        .DATA_W (DATA_W),
        .DEPTH  (DEPTH),
        .IDX_W  (IDX_W)
    ) u_array (
        .clk_i   (CLK),
        .we_i    (load_we),
        .waddr_i (load_idx),
        .wdata_i (LoadData),
        .raddr_i (rd_idx),
        .rdata_o (rd_data)
    );

`ifdef IMEM_PREFETCH_EN
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic [ADDR_W-1:0] pf_tag_q, pf_tag_d;
    logic [DATA_W-1:0] pf_data_q, pf_data_d;
    logic              pf_valid_q, pf_valid_d;
    logic [ADDR_W-1:0] pf_next;
    logic              pf_hit;

    assign pf_next = addr_q + ADDR_W'(4);
    assign pf_hit  = pf_valid_q && (Address == pf_tag_q);

    // The single read port is free while in RESP, so it serves the next-word fill then.
    assign rd_addr = (state_q == RESP) ? pf_next : Address;

    always_comb begin
        addr_d     = addr_q;
        pf_tag_d   = pf_tag_q;
        pf_data_d  = pf_data_q;
        pf_valid_d = pf_valid_q;
        if (state_q == IDLE && ReqValid) begin
            addr_d = Address;
        end
        if (state_q == RESP && RespReady) begin
            pf_tag_d   = pf_next;
            pf_data_d  = rd_data;
            pf_valid_d = addr_ok(MAX_ADDR_W'(pf_next), DEPTH) && !(load_we && (LoadAddr == pf_next));
        end else if (load_we && (LoadAddr == pf_tag_q)) begin
            pf_valid_d = 1'b0;
        end
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            addr_q     <= '0;
            pf_tag_q   <= '0;
            pf_data_q  <= '0;
            pf_valid_q <= 1'b0;
        end else begin
            addr_q     <= addr_d;
            pf_tag_q   <= pf_tag_d;
            pf_data_q  <= pf_data_d;
            pf_valid_q <= pf_valid_d;
        end
    end
`else
    assign rd_addr = Address;
`endif

    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        data_d  = data_q;
        fault_d = fault_q;
        case (state_q)
            IDLE: begin
                if (ReqValid) begin
                    state_d = WAIT;
                    cnt_d   = LAT_M1;
                    data_d  = req_ok ? rd_data : '0;
                    fault_d = !req_ok;
`ifdef IMEM_PREFETCH_EN
                    if (pf_hit) begin
                        cnt_d   = '0;
                        data_d  = pf_data_q;
                        fault_d = 1'b0;
                    end
`endif
                end
            end
            WAIT: begin
                if (cnt_q == '0) begin
                    state_d = RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            RESP: begin
                if (RespReady) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge CLK or posedge Reset) begin
        if (Reset) begin
            state_q <= IDLE;
            cnt_q   <= '0;
            data_q  <= '0;
            fault_q <= 1'b0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            data_q  <= data_d;
            fault_q <= fault_d;
        end
    end

    assign ReqReady  = (state_q == IDLE);
    assign RespValid = (state_q == RESP);
    assign Data      = RespValid ? data_q : '0;
    assign Fault     = RespValid && fault_q;

endmodule

// File: tb/tb_sync_instruction_memory.sv
// tb/tb_sync_instruction_memory.sv - directed self-checking bench for sync_instruction_memory
module tb_sync_instruction_memory;

    logic        CLK = 1'b0;
    logic        Reset;
    logic        ReqValid;
    logic        ReqReady;
    logic [63:0] Address;
    logic        RespValid;
    logic        RespReady;
    logic [31:0] Data;
    logic        Fault;
    logic        LoadEn;
    logic [63:0] LoadAddr;
    logic [31:0] LoadData;

    int vectors = 0;
    int miscompares = 0;

    sync_instruction_memory #(
        .DATA_W (32),
        .ADDR_W (64),
        .DEPTH  (64),
        .RD_LAT (2)
    ) dut (
        .CLK       (CLK),
        .Reset     (Reset),
        .ReqValid  (ReqValid),
        .ReqReady  (ReqReady),
        .Address   (Address),
        .RespValid (RespValid),
        .RespReady (RespReady),
        .Data      (Data),
        .Fault     (Fault),
        .LoadEn    (LoadEn),
        .LoadAddr  (LoadAddr),
        .LoadData  (LoadData)
    );

    always #5 CLK = ~CLK;

    task automatic tick();
        @(posedge CLK);
        #1;
    endtask

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic load(input logic [63:0] a, input logic [31:0] d);
        LoadEn = 1'b1; LoadAddr = a; LoadData = d;
        tick();
        LoadEn = 1'b0;
    endtask

    task automatic fetch(input logic [63:0] a, output int lat, output logic [31:0] d, output logic f);
        ReqValid = 1'b1; Address = a;
        tick();
        ReqValid = 1'b0;
        lat = 0;
        while (!RespValid && lat < 20) begin
            tick();
            lat++;
        end
        d = Data; f = Fault;
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
    endtask

    int          lat;
    logic [31:0] d;
    logic        f;
    int          seen;

    initial begin
        Reset = 1'b1; ReqValid = 1'b0; Address = '0; RespReady = 1'b0;
        LoadEn = 1'b0; LoadAddr = '0; LoadData = '0;
        tick(); tick();
        chk("rst_reqready", ReqReady, 1);
        chk("rst_respvalid", RespValid, 0);
        chk("rst_data", Data, 0);
        chk("rst_fault", Fault, 0);
        Reset = 1'b0;
        tick();

        // Basic fetch with RD_LAT=2
        load(64'h0, 32'hF84003E9);
        fetch(64'h0, lat, d, f);
        chk("f0_lat", lat, 2);
        chk("f0_data", d, 32'hF84003E9);
        chk("f0_fault", f, 0);
        chk("f0_idle", ReqReady, 1);
        chk("f0_data_idle", Data, 0);

        // Misaligned and out-of-range
        fetch(64'h2, lat, d, f);
        chk("mis_lat", lat, 2);
        chk("mis_fault", f, 1);
        chk("mis_data", d, 0);
        fetch(64'h100, lat, d, f);
        chk("oor_lat", lat, 2);
        chk("oor_fault", f, 1);
        chk("oor_data", d, 0);

        // Response held under back-pressure
        ReqValid = 1'b1; Address = 64'h0;
        tick();
        ReqValid = 1'b0;
        chk("bp_wait_rv", RespValid, 0);
        tick();
        chk("bp_wait_rv2", RespValid, 0);
        tick();
        for (int i = 0; i < 3; i++) begin
            chk("bp_rv", RespValid, 1);
            chk("bp_data", Data, 32'hF84003E9);
            chk("bp_reqready", ReqReady, 0);
            tick();
        end
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        chk("bp_idle", ReqReady, 1);
        chk("bp_rv_low", RespValid, 0);

        // Reset during WAIT
        ReqValid = 1'b1; Address = 64'h0;
        tick();
        ReqValid = 1'b0;
        chk("rw_in_wait", ReqReady, 0);
        Reset = 1'b1;
        #1;
        chk("rw_rv", RespValid, 0);
        chk("rw_reqready", ReqReady, 1);
        chk("rw_data", Data, 0);
        tick();
        Reset = 1'b0;
        seen = 0;
        for (int i = 0; i < 5; i++) begin
            tick();
            if (RespValid) seen++;
        end
        chk("rw_no_resp", seen, 0);

        // Load to the word being captured on the accept edge
        load(64'h4, 32'h11111111);
        ReqValid = 1'b1; Address = 64'h4;
        LoadEn = 1'b1; LoadAddr = 64'h4; LoadData = 32'h22222222;
        tick();
        ReqValid = 1'b0; LoadEn = 1'b0;
        lat = 0;
        while (!RespValid && lat < 20) begin
            tick();
            lat++;
        end
        chk("col_lat", lat, 2);
        chk("col_old", Data, 32'h11111111);
        RespReady = 1'b1;
        tick();
        RespReady = 1'b0;
        fetch(64'h4, lat, d, f);
        chk("col_new", d, 32'h22222222);

        // Misaligned load ignored; last word addressable
        load(64'h6, 32'hDEADBEEF);
        load(64'hFC, 32'hA5A5A5A5);
        fetch(64'h4, lat, d, f);
        chk("misload_ign", d, 32'h22222222);
        fetch(64'hFC, lat, d, f);
        chk("last_data", d, 32'hA5A5A5A5);
        chk("last_fault", f, 0);

`ifdef IMEM_PREFETCH_EN
        fetch(64'h0, lat, d, f);
        chk("pf_first_lat", lat, 2);
        fetch(64'h4, lat, d, f);
        chk("pf_hit_lat", lat, 1);
        chk("pf_hit_data", d, 32'h22222222);
        fetch(64'h0, lat, d, f);
        load(64'h4, 32'h33333333);
        fetch(64'h4, lat, d, f);
        chk("pf_inv_lat", lat, 2);
        chk("pf_inv_data", d, 32'h33333333);
`else
        fetch(64'h0, lat, d, f);
        fetch(64'h4, lat, d, f);
        chk("nopf_lat", lat, 2);
        chk("nopf_data", d, 32'h22222222);
`endif

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
